// File: rtl/light_phase_timer.sv
// light_phase_timer: per-phase dwell timer that sits upstream of light_controller.
// Counts CLK cycles in the current light phase, issues a single registered advance pulse
// once the dwell is reached, and flags the illegal code 11.
// Optional feature macro: PED_REQ_EN enables the pedestrian green cut.
module light_phase_timer #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned RED_CYC       = 20,
  parameter int unsigned GREEN_CYC     = 30,
  parameter int unsigned YELLOW_CYC    = 5,
  parameter int unsigned PED_GREEN_MIN = 10
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             en,
  input  logic [1:0]       light,
  input  logic             ped_req,
  output logic             adv,
  output logic [CNT_W-1:0] remaining,
  output logic             ped_pending,
  output logic             fault
);

  localparam logic [1:0] LP_RED_CODE   = 2'b00;
  localparam logic [1:0] LP_GREEN_CODE = 2'b01;
  localparam logic [1:0] LP_YEL_CODE   = 2'b10;

  localparam logic [CNT_W-1:0] LP_RED   = CNT_W'(RED_CYC);
  localparam logic [CNT_W-1:0] LP_GREEN = CNT_W'(GREEN_CYC);
  localparam logic [CNT_W-1:0] LP_YEL   = CNT_W'(YELLOW_CYC);
  // Code 11 gets a two-cycle dwell: fault on the sampling edge, adv on the next one.
  localparam logic [CNT_W-1:0] LP_ILL   = CNT_W'(2);
  localparam logic [CNT_W-1:0] LP_MAX   = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_prev;
  logic             r_adv;
  logic             r_done;
  logic             r_fault;

  logic             w_chg;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_hit;
  logic             w_done_live;
  logic             w_adv_d;
  logic             w_done_d;
  logic             w_ped;
  logic             w_ped_d;
  logic [CNT_W:0]   w_deff;

  function automatic logic [CNT_W-1:0] f_dwell(input logic [1:0] code);
    logic [CNT_W-1:0] d;
    case (code)
      LP_RED_CODE:   d = LP_RED;
      LP_GREEN_CODE: d = LP_GREEN;
      LP_YEL_CODE:   d = LP_YEL;
      default:       d = LP_ILL;
    endcase
    return d;
  endfunction

`ifdef PED_REQ_EN
  localparam logic [CNT_W-1:0] LP_PED_MIN = CNT_W'(PED_GREEN_MIN);

  logic r_ped;

  assign w_ped = r_ped;

  // Pending request is sticky outside red and cleared by the first red sample.
  always_comb begin
    w_ped_d = r_ped;
    if (light == LP_RED_CODE) begin
      w_ped_d = 1'b0;
    end else if (ped_req) begin
      w_ped_d = 1'b1;
    end
  end

  // Pedestrian request latch; only advances on enabled edges.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_ped <= 1'b0;
    end else if (en) begin
      r_ped <= w_ped_d;
    end
  end
`else
  logic w_unused_ped;

  assign w_ped        = 1'b0;
  assign w_ped_d      = 1'b0;
  assign w_unused_ped = ped_req ^ (PED_GREEN_MIN == 0);
`endif

  // Next count, advance decision and done tracking for the edge about to happen.
  always_comb begin
    w_chg = (light != r_prev);
    if (w_chg) begin
      w_cnt_d = CNT_W'(1);
    end else if (r_cnt == LP_MAX) begin
      w_cnt_d = r_cnt;
    end else begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
    w_hit = (w_cnt_d == f_dwell(light));
`ifdef PED_REQ_EN
    // Pending pedestrian: green ends at the later of PED_GREEN_MIN and the next cycle.
    if ((light == LP_GREEN_CODE) && w_ped && (w_cnt_d >= LP_PED_MIN)) begin
      w_hit = 1'b1;
    end
`endif
    w_done_live = r_done && !w_chg;
    w_adv_d     = w_hit && !w_done_live;
    w_done_d    = w_done_live || w_adv_d;
  end

  // Phase counter, advance pulse and fault flag; en=0 freezes everything but drops adv.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_cnt   <= '0;
      r_prev  <= LP_RED_CODE;
      r_adv   <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else if (en) begin
      r_cnt   <= w_cnt_d;
      r_prev  <= light;
      r_adv   <= w_adv_d;
      r_done  <= w_done_d;
      r_fault <= (light == 2'b11);
    end else begin
      r_adv   <= 1'b0;
    end
  end

  // Cycles left in the counted phase, using the pedestrian-shortened dwell when it applies.
  always_comb begin
    w_deff = {1'b0, f_dwell(r_prev)};
`ifdef PED_REQ_EN
    if ((r_prev == LP_GREEN_CODE) && w_ped) begin
      if (r_cnt < LP_PED_MIN) begin
        w_deff = {1'b0, LP_PED_MIN};
      end else begin
        // One bit wider so cnt+1 cannot wrap at saturation.
        w_deff = {1'b0, r_cnt} + (CNT_W+1)'(1);
      end
    end
`endif
    remaining = '0;
    if (!r_done && ({1'b0, r_cnt} <= w_deff)) begin
      remaining = CNT_W'(w_deff - {1'b0, r_cnt});
    end
  end

  assign adv         = r_adv;
  assign fault       = r_fault;
  assign ped_pending = w_ped;

endmodule

// File: tb/tb_light_phase_timer.sv
// Self-checking bench for light_phase_timer (RED=4, GREEN=6, YELLOW=2, PED_GREEN_MIN=3).
module tb_light_phase_timer;

  localparam int CW   = 8;
  localparam int RED  = 4;
  localparam int GRN  = 6;
  localparam int YEL  = 2;
  localparam int PMIN = 3;

  logic          CLK = 1'b0;
  logic          RES = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    light = 2'b00;
  logic          ped_req = 1'b0;
  logic          adv;
  logic [CW-1:0] remaining;
  logic          ped_pending;
  logic          fault;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: phase being timed, cycles spent in it, whether it already advanced.
  logic [1:0] m_phase;
  int         m_age;
  bit         m_fired;
  bit         m_adv;
  bit         m_ped;
  bit         m_fault;

  typedef struct {
    logic       en;
    logic [1:0] light;
    logic       ped;
    logic       adv;
    int         rem;
    logic       fault;
  } vec_t;

  vec_t tbl [15];

  light_phase_timer #(
    .CNT_W        (CW),
    .RED_CYC      (RED),
    .GREEN_CYC    (GRN),
    .YELLOW_CYC   (YEL),
    .PED_GREEN_MIN(PMIN)
  ) dut (
    .CLK        (CLK),
    .RES        (RES),
    .en         (en),
    .light      (light),
    .ped_req    (ped_req),
    .adv        (adv),
    .remaining  (remaining),
    .ped_pending(ped_pending),
    .fault      (fault)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int base_dwell(input logic [1:0] c);
    case (c)
      2'b00:   return RED;
      2'b01:   return GRN;
      2'b10:   return YEL;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] next_code(input logic [1:0] c);
    case (c)
      2'b00:   return 2'b01;
      2'b01:   return 2'b10;
      default: return 2'b00 | {1'b0, (c == 2'b11) ? 1'b0 : 1'b0} | ((c == 2'b11) ? 2'b10 : 2'b00);
    endcase
  endfunction

  function automatic int exp_remaining();
    int tgt;
    if (m_fired) return 0;
    tgt = base_dwell(m_phase);
`ifdef PED_REQ_EN
    if (m_phase == 2'b01 && m_ped) tgt = (PMIN > m_age + 1) ? PMIN : m_age + 1;
`endif
    return (m_age <= tgt) ? tgt - m_age : 0;
  endfunction

  task automatic model_reset();
    m_phase = 2'b00;
    m_age   = 0;
    m_fired = 0;
    m_adv   = 0;
    m_ped   = 0;
    m_fault = 0;
  endtask

  // One enabled/disabled rising edge of the model, using the inputs currently driven.
  task automatic model_edge();
    bit hit;
    bit ped_old;
    if (!en) begin
      m_adv = 0;
      return;
    end
    ped_old = m_ped;
    if (light != m_phase) begin
      m_phase = light;
      m_age   = 1;
      m_fired = 0;
    end else begin
      m_age++;
    end
    hit = (m_age == base_dwell(light));
`ifdef PED_REQ_EN
    if (light == 2'b01 && ped_old && m_age >= PMIN) hit = 1;
    if (light == 2'b00) m_ped = 0;
    else if (ped_req) m_ped = 1;
`else
    ped_old = ped_old;
`endif
    m_adv = hit && !m_fired;
    if (m_adv) m_fired = 1;
    m_fault = (light == 2'b11);
  endtask

  task automatic check_model(input string tag);
    check({tag, " adv"}, adv, m_adv);
    check({tag, " remaining"}, remaining, exp_remaining());
    check({tag, " fault"}, fault, m_fault);
    check({tag, " ped_pending"}, ped_pending, m_ped);
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    model_edge();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Async reset asserted mid-cycle and checked before any clock edge.
  task automatic apply_reset();
    #2;
    RES = 1'b1;
    model_reset();
    #1;
    check_model("async reset");
    @(negedge CLK);
    RES   = 1'b0;
    light = 2'b00;
    ped_req = 1'b0;
  endtask

  initial begin
    int first_adv;
    int last;
    int periods[$];
    int bad;
    bit got;

    tbl[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 3, 1'b0};
    tbl[1]  = '{1'b1, 2'b00, 1'b0, 1'b0, 2, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 1'b0, 2, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 1'b0, 1'b0, 2, 1'b0};
    tbl[4]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1, 1'b0};
    tbl[5]  = '{1'b1, 2'b00, 1'b0, 1'b1, 0, 1'b0};
    tbl[6]  = '{1'b1, 2'b01, 1'b0, 1'b0, 5, 1'b0};
    tbl[7]  = '{1'b1, 2'b01, 1'b0, 1'b0, 4, 1'b0};
    tbl[8]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1, 1'b1};
    tbl[9]  = '{1'b1, 2'b11, 1'b0, 1'b1, 0, 1'b1};
    tbl[10] = '{1'b1, 2'b10, 1'b0, 1'b0, 1, 1'b0};
    tbl[11] = '{1'b1, 2'b10, 1'b0, 1'b1, 0, 1'b0};
    tbl[12] = '{1'b1, 2'b10, 1'b0, 1'b0, 0, 1'b0};
    tbl[13] = '{1'b1, 2'b00, 1'b1, 1'b0, 3, 1'b0};
    tbl[14] = '{1'b1, 2'b00, 1'b1, 1'b0, 2, 1'b0};

    model_reset();
    @(negedge CLK);
    apply_reset();
    check("reset remaining const", remaining, RED);

    // Table: fixed light codes with hand-derived expectations.
    for (int i = 0; i < 15; i++) begin
      en      = tbl[i].en;
      light   = tbl[i].light;
      ped_req = tbl[i].ped;
      step();
      check($sformatf("vec%0d adv", i), adv, tbl[i].adv);
      check($sformatf("vec%0d remaining", i), remaining, tbl[i].rem);
      check($sformatf("vec%0d fault", i), fault, tbl[i].fault);
      check($sformatf("vec%0d ped_pending", i), ped_pending, 1'b0);
    end
    ped_req = 1'b0;

    // Free run: light follows adv; adv spacing must be 6 (green), 2 (yellow), 4 (red).
    apply_reset();
    en = 1'b1;
    first_adv = -1;
    last = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      check_model("free run");
      if (c <= 4) check("red countdown", remaining, 4 - c);
      if (adv === 1'b1) begin
        if (first_adv < 0) first_adv = c;
        if (last >= 0) periods.push_back(c - last);
        last = c;
        light = next_code(light);
      end
    end
    check("first red adv cycle", first_adv, 4);
    check("adv period count", periods.size() >= 3, 1);
    if (periods.size() >= 3) begin
      check("green period", periods[0], 6);
      check("yellow period", periods[1], 2);
      check("red period", periods[2], 4);
    end

    // Hold: freeze light at green after its adv; no further adv through counter saturation.
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (adv === 1'b1) begin
        if (light == 2'b01) got = 1;
        else light = next_code(light);
      end
    end
    check("reached green adv", got, 1);
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      check_model("hold");
      if (adv !== 1'b0 || remaining !== '0) bad++;
    end
    check("hold cycles with adv or remaining", bad, 0);

    // Enable gap at cnt=2 in red.
    apply_reset();
    en = 1'b1;
    step();
    step();
    check("gap start remaining", remaining, 2);
    en = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (adv !== 1'b0 || remaining !== 8'd2) bad++;
    end
    check("gap frozen cycles", bad, 0);
    en = 1'b1;
    step();
    check("gap re-enable edge1 adv", adv, 1'b0);
    step();
    check("gap re-enable edge2 adv", adv, 1'b1);
    check_model("gap");

    // Async reset at cnt=3 in green, then red timing restarts.
    light = 2'b01;
    for (int c = 0; c < 3; c++) step();
    check("pre-reset remaining", remaining, 3);
    apply_reset();
    bad = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_model("post reset");
      if ((adv === 1'b1) != (c == 4)) bad++;
    end
    check("post reset red adv timing", bad, 0);

`ifdef PED_REQ_EN
    // Pedestrian: request in green cycle 1 cuts green at cnt=3.
    light = 2'b01;
    step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check("ped latched", ped_pending, 1'b1);
    check("ped cut remaining", remaining, 1);
    step();
    check("ped cut adv at 3", adv, 1'b1);
    light = 2'b10;
    step();
    step();
    check_model("ped yellow");
    light = 2'b00;
    step();
    check("ped cleared in red", ped_pending, 1'b0);
    for (int c = 0; c < 3; c++) step();
    // Late request at cnt=5 gives adv at cnt=6.
    light = 2'b01;
    for (int c = 0; c < 5; c++) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check("late ped adv at 6", adv, 1'b1);
    check_model("ped late");
`endif

    // Randomised run against the model, with stray codes, enable gaps and resets.
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      en      = ($urandom_range(0, 7) != 0);
      ped_req = ($urandom_range(0, 5) == 0);
      if (adv === 1'b1) light = next_code(light);
      if ($urandom_range(0, 39) == 0) light = 2'($urandom_range(0, 3));
      step();
      check_model("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
